// File: rtl/bhand_pkg.sv
// ---------------------------------------------------------------------------
// bhand_pkg
// Shared helpers for the bhand FIFO slice.
//   clog2   : ceiling log2. Sizes the pointers and the occupancy counter.
//   age_inc : adds a 0/1 strobe to an age value of a given width. At all-ones
//             the result either sticks (saturate) or rolls over to zero.
// ---------------------------------------------------------------------------
package bhand_pkg;

  // Widest age counter the increment helper can handle.
  localparam int AGE_CALC_W = 32;

  // Smallest number of bits that can hold 'value' distinct codes.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // The caller passes 'value' zero-extended and truncates the result back to
  // 'width' bits. An all-ones value is the only case where the two policies
  // (saturate or wrap) give different results.
  function automatic logic [AGE_CALC_W-1:0] age_inc(
    input logic [AGE_CALC_W-1:0] value,
    input logic                  inc,
    input int                    width,
    input bit                    saturate
  );
    logic [AGE_CALC_W-1:0] max_val;
    logic [AGE_CALC_W-1:0] cur;
    max_val = {AGE_CALC_W{1'b1}} >> (AGE_CALC_W - width);
    cur     = value & max_val;
    age_inc = cur;
    if (inc) begin
      if (cur == max_val) age_inc = saturate ? max_val : '0;
      else                age_inc = cur + 1'b1;
    end
  endfunction

endpackage

// File: rtl/bhand_age_ctr.sv
// ---------------------------------------------------------------------------
// bhand_age_ctr
// Age register for one FIFO slot. When the slot is written, the register
// loads the incoming age. On every other cycle it ages by the global strobe.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : this slot is being written this cycle
//   load_val   : initial age of the item being written
//   inc        : global age-increment strobe (cnt_en)
//   count      : current age stored in this slot
// ---------------------------------------------------------------------------
module bhand_age_ctr
  import bhand_pkg::*;
#(
  parameter int COUNT_WIDTH = 4,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] next_count;

  // A freshly written item already sees this cycle's strobe, so the load path
  // and the hold path share the same increment.
  always_comb begin
    next_count = COUNT_WIDTH'(age_inc(AGE_CALC_W'(load ? load_val : count),
                                      inc, COUNT_WIDTH, SATURATE != 0));
  end

  // Age register for this slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= next_count;
  end

endmodule

// File: rtl/bhand_fifo_age.sv
// ---------------------------------------------------------------------------
// bhand_fifo_age
// Register-array FIFO with valid/ready handshakes on both sides. It has an
// optional per-entry age counter, and the head entry's age is shown on ocount.
// Ports:
//   clk, rst_n                  : clock and asynchronous active-low reset
//   idata, idata_vld, idata_rdy : upstream handshake (idata_rdy = !full)
//   odata, odata_vld, odata_rdy : downstream handshake (odata_vld = !empty)
//   cnt_en                      : global age-increment strobe
//   icount                      : initial age of the incoming item
//   ocount                      : age of the head entry
//   level, full, empty          : occupancy status
// Both ready and valid come from the occupancy register only. This means
// neither handshake side has a combinational path to the other.
// ---------------------------------------------------------------------------
module bhand_fifo_age
  import bhand_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int ENABLE_COUNT = 0,
  parameter int COUNT_WIDTH  = 4,
  parameter int SATURATE     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        idata,
  input  logic                         idata_vld,
  output logic                         idata_rdy,
  output logic [DATA_WIDTH-1:0]        odata,
  output logic                         odata_vld,
  input  logic                         odata_rdy,
  input  logic                         cnt_en,
  input  logic [COUNT_WIDTH-1:0]       icount,
  output logic [COUNT_WIDTH-1:0]       ocount,
  output logic [clog2(DEPTH+1)-1:0]    level,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly at DEPTH-1, so DEPTH does not have to be a
  // power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign level     = level_q;
  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign idata_rdy = !full;
  assign odata_vld = !empty;
  assign push      = idata_vld && idata_rdy;
  assign pop       = odata_vld && odata_rdy;

  // Pointer and occupancy bookkeeping. When push and pop happen together,
  // both pointers advance and the level stays the same. When the FIFO is
  // full, push is already blocked, so a pop frees a slot that only becomes
  // writable on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Payload storage is not reset. Stale contents are never shown, because
  // odata is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= idata;
  end

  assign odata = odata_vld ? mem[rd_ptr] : '0;

  generate
    if (ENABLE_COUNT != 0) begin : g_age
      logic [COUNT_WIDTH-1:0] age [DEPTH];

      for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        bhand_age_ctr #(
          .COUNT_WIDTH (COUNT_WIDTH),
          .SATURATE    (SATURATE)
        ) u_ctr (
          .clk      (clk),
          .rst_n    (rst_n),
          .load     (push && (wr_ptr == PTR_W'(i))),
          .load_val (icount),
          .inc      (cnt_en),
          .count    (age[i])
        );
      end

      assign ocount = odata_vld ? age[rd_ptr] : '0;
    end else begin : g_no_age
      logic unused_age_inputs;
      assign unused_age_inputs = ^{icount, cnt_en};
      assign ocount = '0;
    end
  endgenerate

endmodule

// File: tb/tb_bhand_fifo_age.sv
// ---------------------------------------------------------------------------
// tb_bhand_fifo_age
// Two DEPTH=3 instances with age counting enabled share one stimulus stream.
// One instance wraps its ages and the other saturates them. A queue-based
// model tracks what every output should be, and directed literal
// expectations pin down the key scenarios.
// ---------------------------------------------------------------------------
module tb_bhand_fifo_age;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 4;
  localparam int LW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          idata_vld = 1'b0;
  logic          odata_rdy = 1'b0;
  logic          cnt_en = 1'b0;
  logic [CW-1:0] icount = '0;

  logic          w_idata_rdy, w_odata_vld, w_full, w_empty;
  logic [DW-1:0] w_odata;
  logic [CW-1:0] w_ocount;
  logic [LW-1:0] w_level;
  logic          s_idata_rdy, s_odata_vld, s_full, s_empty;
  logic [DW-1:0] s_odata;
  logic [CW-1:0] s_ocount;
  logic [LW-1:0] s_level;

  bhand_fifo_age #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ENABLE_COUNT(1), .COUNT_WIDTH(CW), .SATURATE(0)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .idata(idata), .idata_vld(idata_vld),
    .idata_rdy(w_idata_rdy), .odata(w_odata), .odata_vld(w_odata_vld),
    .odata_rdy(odata_rdy), .cnt_en(cnt_en), .icount(icount), .ocount(w_ocount),
    .level(w_level), .full(w_full), .empty(w_empty)
  );

  bhand_fifo_age #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ENABLE_COUNT(1), .COUNT_WIDTH(CW), .SATURATE(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .idata(idata), .idata_vld(idata_vld),
    .idata_rdy(s_idata_rdy), .odata(s_odata), .odata_vld(s_odata_vld),
    .odata_rdy(odata_rdy), .cnt_en(cnt_en), .icount(icount), .ocount(s_ocount),
    .level(s_level), .full(s_full), .empty(s_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point: every check, from the model or directed, goes here.
  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of payloads with parallel age queues.
  int m_data[$];
  int m_age_w[$];
  int m_age_s[$];
  bit m_push, m_pop;

  function automatic int age_wrap(input int a, input bit e);
    return (a + int'(e)) % 16;
  endfunction

  function automatic int age_sat(input int a, input bit e);
    int s;
    s = a + int'(e);
    return (s > 15) ? 15 : s;
  endfunction

  // Update the model at each rising edge: age the stored items, drop the head
  // on a pop, then append an accepted item with its initial age.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data.delete();
      m_age_w.delete();
      m_age_s.delete();
    end else begin
      m_push = idata_vld && (m_data.size() < DEPTH);
      m_pop  = (m_data.size() > 0) && odata_rdy;
      foreach (m_age_w[i]) begin
        m_age_w[i] = age_wrap(m_age_w[i], cnt_en);
        m_age_s[i] = age_sat(m_age_s[i], cnt_en);
      end
      if (m_pop) begin
        void'(m_data.pop_front());
        void'(m_age_w.pop_front());
        void'(m_age_s.pop_front());
      end
      if (m_push) begin
        m_data.push_back(int'(idata));
        m_age_w.push_back(age_wrap(int'(icount), cnt_en));
        m_age_s.push_back(age_sat(int'(icount), cnt_en));
      end
    end
  end

  task automatic compare_dut(input string tag, input logic [LW-1:0] lvl,
                             input logic f, input logic e, input logic rdy,
                             input logic vld, input logic [DW-1:0] od,
                             input logic [CW-1:0] oc, input bit sat);
    int n;
    n = m_data.size();
    check_output({tag, "_level"}, lvl, n);
    check_output({tag, "_full"}, f, n == DEPTH);
    check_output({tag, "_empty"}, e, n == 0);
    check_output({tag, "_idata_rdy"}, rdy, n != DEPTH);
    check_output({tag, "_odata_vld"}, vld, n != 0);
    if (n > 0) begin
      check_output({tag, "_odata"}, od, m_data[0]);
      check_output({tag, "_ocount"}, oc, sat ? m_age_s[0] : m_age_w[0]);
    end else if (!rst_n) begin
      check_output({tag, "_rst_odata"}, od, 0);
      check_output({tag, "_rst_ocount"}, oc, 0);
    end
  endtask

  // Check both instances against the model on every falling edge.
  always @(negedge clk) begin
    compare_dut("wrap", w_level, w_full, w_empty, w_idata_rdy, w_odata_vld,
                w_odata, w_ocount, 1'b0);
    compare_dut("sat", s_level, s_full, s_empty, s_idata_rdy, s_odata_vld,
                s_odata, s_ocount, 1'b1);
  end

  // Drive one cycle of inputs and return just after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                input logic r, input logic c,
                                input logic [CW-1:0] ic);
    idata_vld = v;
    idata     = d;
    odata_rdy = r;
    cnt_en    = c;
    icount    = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input string name, input logic [63:0] w_act,
                            input logic [63:0] s_act, input logic [63:0] expected);
    check_output({"wrap_", name}, w_act, expected);
    check_output({"sat_", name}, s_act, expected);
  endtask

  initial begin
    $display("[TB] starting bhand_fifo_age directed run");
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    check_pair("rst_level", w_level, s_level, 0);
    check_pair("rst_empty", w_empty, s_empty, 1);
    check_pair("rst_full", w_full, s_full, 0);
    check_pair("rst_idata_rdy", w_idata_rdy, s_idata_rdy, 1);
    check_pair("rst_odata_vld", w_odata_vld, s_odata_vld, 0);
    check_pair("rst_odata", w_odata, s_odata, 0);
    check_pair("rst_ocount", w_ocount, s_ocount, 0);
    rst_n = 1'b1;

    // Fill to DEPTH with the sink stalled.
    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0, 4'd0);
    check_pair("first_push_vld", w_odata_vld, s_odata_vld, 1);
    check_pair("first_push_odata", w_odata, s_odata, 8'hA1);
    apply_stimulus(1'b1, 8'hB2, 1'b0, 1'b0, 4'd0);
    apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0, 4'd0);
    check_pair("fill_level", w_level, s_level, 3);
    check_pair("fill_full", w_full, s_full, 1);
    check_pair("fill_idata_rdy", w_idata_rdy, s_idata_rdy, 0);
    check_pair("fill_odata", w_odata, s_odata, 8'hA1);
    apply_stimulus(1'b1, 8'hD4, 1'b0, 1'b0, 4'd0);
    check_pair("full_refuse_level", w_level, s_level, 3);
    check_pair("full_hold_odata", w_odata, s_odata, 8'hA1);

    // Pop from full: ready stays low this cycle and rises on the next.
    odata_rdy = 1'b1;
    #1;
    check_pair("pop_full_rdy_same", w_idata_rdy, s_idata_rdy, 0);
    apply_stimulus(1'b1, 8'hD4, 1'b1, 1'b0, 4'd0);
    check_pair("pop_full_rdy_next", w_idata_rdy, s_idata_rdy, 1);
    check_pair("pop_full_level", w_level, s_level, 2);
    check_pair("pop_full_odata", w_odata, s_odata, 8'hB2);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    check_pair("drain_odata", w_odata, s_odata, 8'hC3);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    check_pair("drain_empty", w_empty, s_empty, 1);

    // Stream at level 1: the pointers wrap several times at DEPTH=3.
    apply_stimulus(1'b1, 8'h50, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 4'd0);
      check_pair("stream_level", w_level, s_level, 1);
      check_pair("stream_odata", w_odata, s_odata, 8'(8'h50 + i));
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    check_pair("stream_empty", w_empty, s_empty, 1);

    // Item pushed with age 2 under a held strobe reads 7 when it is popped.
    apply_stimulus(1'b1, 8'h77, 1'b0, 1'b1, 4'd2);
    check_pair("age_load", w_ocount, s_ocount, 3);
    repeat (4) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
    check_pair("age_at_pop", w_ocount, s_ocount, 7);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd0);
    check_pair("age_pop_empty", w_empty, s_empty, 1);

    // Age 14 with the strobe held: wrap gives 15,0,1,2 and saturate gives 15,15,15,15.
    apply_stimulus(1'b1, 8'h88, 1'b0, 1'b1, 4'd14);
    check_output("wrap_age14_c0", w_ocount, 15);
    check_output("sat_age14_c0", s_ocount, 15);
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
      check_output("wrap_age14_ck", w_ocount, k - 1);
      check_output("sat_age14_ck", s_ocount, 15);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);

    // Loading an all-ones age with the strobe high.
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1, 4'd15);
    check_output("wrap_age15_load", w_ocount, 0);
    check_output("sat_age15_load", s_ocount, 15);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);

    // Asynchronous reset in the middle of a cycle with two items stored.
    apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0, 4'd0);
    apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0, 4'd0);
    check_pair("pre_reset_level", w_level, s_level, 2);
    idata_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_pair("async_rst_vld", w_odata_vld, s_odata_vld, 0);
    check_pair("async_rst_empty", w_empty, s_empty, 1);
    check_pair("async_rst_level", w_level, s_level, 0);
    check_pair("async_rst_odata", w_odata, s_odata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0, 4'd0);
    check_pair("post_rst_odata", w_odata, s_odata, 8'h33);
    check_pair("post_rst_level", w_level, s_level, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    check_pair("post_rst_empty", w_empty, s_empty, 1);

    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
